// File: rtl/cmd_ring_parser_if.sv
// ---------------------------------------------------------------------------
// cmd_ring_parser_if
//   Groups the two handshakes of the command ring parser:
//     - ring queue show-ahead read port : q_empty, q_dout, q_pop
//     - dispatch beat port (valid/ready): cmd_valid, cmd_ready, cmd_data,
//                                         cmd_first, cmd_last
//   master : the parser (pops the queue, drives beats)
//   slave  : the environment (queue + downstream dispatch unit)
// ---------------------------------------------------------------------------
interface cmd_ring_parser_if;
  logic        q_empty;
  logic [63:0] q_dout;
  logic        q_pop;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_data;
  logic        cmd_first;
  logic        cmd_last;

  modport master (
    input  q_empty, q_dout, cmd_ready,
    output q_pop, cmd_valid, cmd_data, cmd_first, cmd_last
  );

  modport slave (
    output q_empty, q_dout, cmd_ready,
    input  q_pop, cmd_valid, cmd_data, cmd_first, cmd_last
  );
endinterface

// File: rtl/cmd_ring_parser.sv
// ---------------------------------------------------------------------------
// cmd_ring_parser
//   Pops 64-bit words from the command ring queue and frames them into
//   header/payload commands for the dispatch unit. Header word layout:
//   [63:56] opcode, [55:48] payload count N, [47:0] operand.
//   NOP commands are dropped with their payload; FENCE blocks parsing until
//   the downstream reports idle; oversize headers are discarded with an
//   err_len pulse.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   bus          queue read port + output beat port (see cmd_ring_parser_if)
//   ds_idle      downstream has drained all issued commands
//   err_len      one-cycle pulse: header N > MAX_PAYLOAD
//   busy         parser mid-command / fenced, or a beat is pending
//   cmds_issued  headers accepted downstream (wraps)
// ---------------------------------------------------------------------------
module cmd_ring_parser #(
  parameter int          MAX_PAYLOAD = 32,
  parameter logic [7:0]  NOP_OP      = 8'h00,
  parameter logic [7:0]  FENCE_OP    = 8'hFF,
  parameter int          CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cmd_ring_parser_if.master    bus,
  input  logic                 ds_idle,
  output logic                 err_len,
  output logic                 busy,
  output logic [CNT_W-1:0]     cmds_issued
);

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_PAY   = 2'd1,
    ST_DROP  = 2'd2,
    ST_FENCE = 2'd3
  } state_e;

  localparam logic [7:0] MAX_N = 8'(MAX_PAYLOAD);

  state_e             state_q, state_d;
  logic [7:0]         remaining_q, remaining_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [63:0]        cmd_data_q, cmd_data_d;
  logic               cmd_first_q, cmd_first_d;
  logic               cmd_last_q, cmd_last_d;
  logic               err_len_q, err_len_d;
  logic [CNT_W-1:0]   cmds_issued_q, cmds_issued_d;

  logic               slot_free;
  logic               pop;
  logic               load;
  logic               load_first;
  logic               load_last;
  logic [7:0]         hdr_op;
  logic [7:0]         hdr_n;

  assign hdr_op    = bus.q_dout[63:56];
  assign hdr_n     = bus.q_dout[55:48];
  // The output register can take a new beat if it is empty or being drained.
  assign slot_free = !cmd_valid_q || bus.cmd_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips the assignment would infer a latch.
    state_d       = state_q;
    remaining_d   = remaining_q;
    pop           = 1'b0;
    load          = 1'b0;
    load_first    = 1'b0;
    load_last     = 1'b0;
    err_len_d     = 1'b0;

    unique case (state_q)
      ST_HDR: begin
        if (!bus.q_empty) begin
          if (hdr_op == FENCE_OP) begin
            // FENCE carries no payload; its N field is ignored.
            pop     = 1'b1;
            state_d = ST_FENCE;
          end else if (hdr_n > MAX_N) begin
            // Discard the bad header; the next word is taken as a header.
            pop       = 1'b1;
            err_len_d = 1'b1;
          end else if (hdr_op == NOP_OP) begin
            // NOP never occupies the output slot, so it pops unconditionally.
            pop         = 1'b1;
            remaining_d = hdr_n;
            if (hdr_n != 8'd0) state_d = ST_DROP;
          end else if (slot_free) begin
            pop        = 1'b1;
            load       = 1'b1;
            load_first = 1'b1;
            load_last  = (hdr_n == 8'd0);
            if (hdr_n != 8'd0) begin
              remaining_d = hdr_n;
              state_d     = ST_PAY;
            end
          end
        end
      end

      ST_PAY: begin
        if (remaining_q == 8'd0) begin
          state_d = ST_HDR;
        end else if (!bus.q_empty && slot_free) begin
          pop         = 1'b1;
          load        = 1'b1;
          load_last   = (remaining_q == 8'd1);
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) state_d = ST_HDR;
        end
      end

      ST_DROP: begin
        if (remaining_q == 8'd0) begin
          state_d = ST_HDR;
        end else if (!bus.q_empty) begin
          pop         = 1'b1;
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) state_d = ST_HDR;
        end
      end

      ST_FENCE: begin
        // Wait until everything issued (including our own pending beat) is gone.
        if (ds_idle && !cmd_valid_q) state_d = ST_HDR;
      end

      default: state_d = ST_HDR;
    endcase

    // Output register: load a new beat, else drop the accepted one, else hold.
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    cmd_first_d = cmd_first_q;
    cmd_last_d  = cmd_last_q;
    if (load) begin
      cmd_valid_d = 1'b1;
      cmd_data_d  = bus.q_dout;
      cmd_first_d = load_first;
      cmd_last_d  = load_last;
    end else if (bus.cmd_ready) begin
      cmd_valid_d = 1'b0;
    end

    cmds_issued_d = cmds_issued_q;
    if (cmd_valid_q && bus.cmd_ready && cmd_first_q)
      cmds_issued_d = cmds_issued_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_HDR;
      remaining_q   <= 8'd0;
      cmd_valid_q   <= 1'b0;
      cmd_data_q    <= 64'd0;
      cmd_first_q   <= 1'b0;
      cmd_last_q    <= 1'b0;
      err_len_q     <= 1'b0;
      cmds_issued_q <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_data_q    <= cmd_data_d;
      cmd_first_q   <= cmd_first_d;
      cmd_last_q    <= cmd_last_d;
      err_len_q     <= err_len_d;
      cmds_issued_q <= cmds_issued_d;
    end
  end

  // Gate with rst_n so no word is consumed while the parser is held in reset.
  assign bus.q_pop     = pop && rst_n;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_data  = cmd_data_q;
  assign bus.cmd_first = cmd_first_q;
  assign bus.cmd_last  = cmd_last_q;
  assign err_len       = err_len_q;
  assign busy          = (state_q != ST_HDR) || cmd_valid_q;
  assign cmds_issued   = cmds_issued_q;

endmodule

// File: tb/tb_cmd_ring_parser.sv
// ---------------------------------------------------------------------------
// tb_cmd_ring_parser
//   Queue model feeds the parser; expected beats go to a scoreboard when a
//   command is pushed and are compared as the DUT hands them off.
//   DUT outputs are sampled on the falling edge; stimulus changes just after
//   the rising edge.
// ---------------------------------------------------------------------------
module tb_cmd_ring_parser;

  localparam int         MAX_PAYLOAD = 32;
  localparam logic [7:0] NOP_OP      = 8'h00;
  localparam logic [7:0] FENCE_OP    = 8'hFF;
  localparam int         CNT_W       = 32;

  typedef struct {
    logic [63:0] data;
    logic        first;
    logic        last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ds_idle = 1'b1;
  logic             err_len;
  logic             busy;
  logic [CNT_W-1:0] cmds_issued;

  cmd_ring_parser_if bus ();

  cmd_ring_parser #(
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .NOP_OP      (NOP_OP),
    .FENCE_OP    (FENCE_OP),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ds_idle     (ds_idle),
    .err_len     (err_len),
    .busy        (busy),
    .cmds_issued (cmds_issued)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] fifo[$];
  beat_t       sb[$];
  int          hs_cyc[$];
  int          pop_count = 0;
  int          applied_pops = 0;
  int          beat_count = 0;
  int          err_cycles = 0;
  int          cyc = 0;
  int          exp_issued = 0;
  logic        ready_fixed = 1'b1;
  logic        rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Queue and ready model: applies pops seen on the previous falling edge.
  initial begin
    bus.q_empty   = 1'b1;
    bus.q_dout    = 64'd0;
    bus.cmd_ready = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    while (applied_pops < pop_count) begin
      if (fifo.size() != 0) fifo.delete(0);
      applied_pops++;
    end
    bus.cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    bus.q_empty   = (fifo.size() == 0);
    bus.q_dout    = (fifo.size() != 0) ? fifo[0] : 64'd0;
  end

  // Monitor / scoreboard compare.
  always @(negedge clk) begin
    if (bus.q_pop) begin
      check("pop_while_empty", bus.q_empty, 1'b0);
      pop_count++;
    end
    if (err_len) err_cycles++;
    if (bus.cmd_valid && bus.cmd_ready) begin
      beat_t e;
      beat_count++;
      hs_cyc.push_back(cyc);
      check("beat_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("beat_data", bus.cmd_data, e.data);
        check("beat_first", bus.cmd_first, e.first);
        check("beat_last", bus.cmd_last, e.last);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Push a header plus npay payload words; expected beats are derived here.
  task automatic push_cmd(input logic [7:0] op, input logic [7:0] n, input int npay);
    logic [63:0] w;
    logic        issue;
    issue = (op != NOP_OP) && (op != FENCE_OP) && (n <= 8'(MAX_PAYLOAD));
    w = {op, n, 16'hC0DE, $urandom()};
    fifo.push_back(w);
    if (issue) begin
      sb.push_back('{data: w, first: 1'b1, last: (n == 8'd0)});
      exp_issued++;
    end
    for (int i = 1; i <= npay; i++) begin
      w = {$urandom(), $urandom()};
      fifo.push_back(w);
      if (issue) sb.push_back('{data: w, first: 1'b0, last: (i == int'(n))});
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while ((sb.size() != 0 || fifo.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, (sb.size() != 0 || fifo.size() != 0), 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int p0, b0, e0, k;
    logic [63:0] hdr;

    // Reset
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_cmd_valid", bus.cmd_valid, 1'b0);
    check("rst_q_pop", bus.q_pop, 1'b0);
    check("rst_cmds_issued", cmds_issued, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_err_len", err_len, 1'b0);
    check("rst_cmd_data", {bus.cmd_first, bus.cmd_last, bus.cmd_data}, 0);
    step();
    rst_n = 1'b1;
    step();

    // 1: N=2 command, back-to-back beats
    hs_cyc.delete();
    push_cmd(8'h10, 8'd2, 2);
    wait_drain("t1_drain", 50);
    check("t1_beats", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) check("t1_back_to_back", hs_cyc[2] - hs_cyc[0], 2);
    check("t1_cmds_issued", cmds_issued, exp_issued);

    // 2: backpressure holds the beat and blocks further pops
    ready_fixed = 1'b0;
    step();
    step();
    push_cmd(8'h20, 8'd0, 0);
    hdr = fifo[fifo.size()-1];
    push_cmd(8'h21, 8'd0, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.cmd_valid && k < 20);
    check("t2_valid_seen", bus.cmd_valid, 1'b1);
    p0 = pop_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", bus.cmd_valid, 1'b1);
      check("t2_hold_data", bus.cmd_data, hdr);
      check("t2_hold_fl", {bus.cmd_first, bus.cmd_last}, 2'b11);
      check("t2_no_pop", pop_count, p0);
    end
    ready_fixed = 1'b1;
    wait_drain("t2_drain", 50);
    check("t2_cmds_issued", cmds_issued, exp_issued);

    // 3: NOP with payload is swallowed
    p0 = pop_count;
    b0 = beat_count;
    push_cmd(NOP_OP, 8'd3, 3);
    push_cmd(8'h11, 8'd0, 0);
    wait_drain("t3_drain", 50);
    check("t3_pops", pop_count - p0, 5);
    check("t3_beats", beat_count - b0, 1);

    // 4: FENCE waits for ds_idle
    ds_idle = 1'b0;
    push_cmd(FENCE_OP, 8'd0, 0);
    push_cmd(8'h12, 8'd0, 0);
    hdr = fifo[fifo.size()-1];
    step();
    @(negedge clk);
    check("t4_fence_pop", bus.q_pop, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_fence_no_pop", bus.q_pop, 1'b0);
      check("t4_fence_no_beat", bus.cmd_valid, 1'b0);
    end
    step();
    ds_idle = 1'b1;
    @(negedge clk);
    check("t4_cyc0_pop", bus.q_pop, 1'b0);
    @(negedge clk);
    check("t4_cyc1_pop", bus.q_pop, 1'b1);
    check("t4_cyc1_valid", bus.cmd_valid, 1'b0);
    @(negedge clk);
    check("t4_cyc2_valid", bus.cmd_valid, 1'b1);
    check("t4_cyc2_data", bus.cmd_data, hdr);
    wait_drain("t4_drain", 50);

    // 5: oversize header, then boundary N=MAX_PAYLOAD
    e0 = err_cycles;
    b0 = beat_count;
    push_cmd(8'h13, 8'(MAX_PAYLOAD + 1), 0);
    push_cmd(8'h14, 8'd0, 0);
    wait_drain("t5_drain", 50);
    check("t5_err_pulse", err_cycles - e0, 1);
    check("t5_beats", beat_count - b0, 1);
    b0 = beat_count;
    push_cmd(8'h15, 8'(MAX_PAYLOAD), MAX_PAYLOAD);
    wait_drain("t5_max_drain", 200);
    check("t5_max_beats", beat_count - b0, MAX_PAYLOAD + 1);
    check("t5_cmds_issued", cmds_issued, exp_issued);

    // Random backpressure with mixed commands
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int n;
      n = $urandom_range(0, 6);
      if (i == 3) push_cmd(NOP_OP, 8'd2, 2);
      else        push_cmd(8'($urandom_range(1, 254)), 8'(n), n);
    end
    wait_drain("rand_drain", 2000);
    rand_ready = 1'b0;
    step();
    step();
    check("rand_cmds_issued", cmds_issued, exp_issued);

    // 6: reset mid-payload (queue underruns first, parser waits in PAY)
    push_cmd(8'h16, 8'd4, 2);
    wait_drain("t6_drain", 50);
    check("t6_busy_mid_pay", busy, 1'b1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_issued = 0;
    @(negedge clk);
    check("t6_valid", bus.cmd_valid, 1'b0);
    check("t6_cmds_issued", cmds_issued, 0);
    check("t6_busy", busy, 1'b0);
    push_cmd(8'h17, 8'd0, 0);
    wait_drain("t6_hdr_drain", 50);
    check("t6_after_cmds", cmds_issued, exp_issued);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
